// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive FIFO, transmitter and register block.
// Keeps byte width and default buffer depth consistent across the UART slice.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;

  typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous (show-ahead) read.
// Contents are deliberately not reset so the array can map onto distributed RAM.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = UART_RX_FIFO_DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO: captures receiver strobes, presents a show-ahead read port,
// and reports level, full, threshold interrupt and a sticky overrun flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W  = UART_DATA_W,
  parameter int DEPTH   = UART_RX_FIFO_DEPTH,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic              flush,
  input  logic [LVL_W-1:0]  thresh,
  input  logic              ovr_clr,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              overrun,
  output logic              thresh_irq
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push;
  logic          pop;
  logic          drop;

  // Read handshake: rd_valid means rd_data holds the head byte; a byte is consumed
  // in every cycle where rd_valid & rd_ready are both high. The write side has no
  // back-pressure: each wr_valid cycle is one byte, dropped (and flagged) when full.
  // Flush takes priority over both sides in the cycle it is asserted.
  assign pop  = rd_valid & rd_ready & ~flush;
  assign push = wr_valid & (~full | pop) & ~flush;
  assign drop = wr_valid & full & ~pop & ~flush;

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wptr),
    .wr_data (wr_data),
    .rd_addr (rptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);
    end
  end

  // A new drop outranks a clear in the same cycle so no loss goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overrun <= 1'b0;
    else if (drop)    overrun <= 1'b1;
    else if (ovr_clr) overrun <= 1'b0;
  end

  assign rd_valid   = (level != '0);
  assign full       = (level == LVL_W'(DEPTH));
  assign thresh_irq = (thresh != '0) && (level >= thresh);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: scenario tasks plus a byte scoreboard
// fed on accepted pushes and drained on observed pops.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int LVL_W = 5;

  logic             clk;
  logic             rst_n;
  uart_byte_t       wr_data;
  logic             wr_valid;
  uart_byte_t       rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             flush;
  logic [LVL_W-1:0] thresh;
  logic             ovr_clr;
  logic [LVL_W-1:0] level;
  logic             full;
  logic             overrun;
  logic             thresh_irq;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         m_level = 0;
  logic       m_ovr = 1'b0;
  logic [7:0] last_pop;

  uart_rx_fifo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .flush      (flush),
    .thresh     (thresh),
    .ovr_clr    (ovr_clr),
    .level      (level),
    .full       (full),
    .overrun    (overrun),
    .thresh_irq (thresh_irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; updates the reference model and checks popped data.
  task automatic drive(input logic wv, input logic [7:0] wd, input logic rr,
                       input logic fl, input logic oc);
    logic m_pop, m_push, m_drop;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    ovr_clr  = oc;
    m_pop  = rr && (m_level != 0) && !fl;
    m_push = wv && ((m_level < DEPTH) || m_pop) && !fl;
    m_drop = wv && (m_level == DEPTH) && !m_pop && !fl;
    if (m_pop) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_q[0]) begin
        errors++;
        $display("FAIL pop_data: got valid=%b data=%h, expected valid=1 data=%h",
                 rd_valid, rd_data, exp_q[0]);
      end
      last_pop = exp_q.pop_front();
    end
    if (fl) begin
      exp_q.delete();
      m_level = 0;
    end else begin
      if (m_push) exp_q.push_back(wd);
      if (m_push && !m_pop)      m_level++;
      else if (m_pop && !m_push) m_level--;
    end
    if (m_drop)  m_ovr = 1'b1;
    else if (oc) m_ovr = 1'b0;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    flush    = 1'b0;
    ovr_clr  = 1'b0;
  endtask

  task automatic drain();
    while (m_level > 0) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    checks++;
    if (level !== 5'd0 || rd_valid !== 1'b0 || full !== 1'b0 ||
        overrun !== 1'b0 || thresh_irq !== 1'b0) begin
      errors++;
      $display("FAIL reset: got level=%0d valid=%b full=%b ovr=%b irq=%b, expected all 0",
               level, rd_valid, full, overrun, thresh_irq);
    end
  endtask

  task automatic test_single();
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || level !== 5'd1) begin
      errors++;
      $display("FAIL single_push: got valid=%b data=%h level=%0d, expected 1 a5 1",
               rd_valid, rd_data, level);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (level !== 5'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: got level=%0d valid=%b, expected 0 0", level, rd_valid);
    end
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    checks++;
    if (full !== 1'b1 || level !== 5'd16) begin
      errors++;
      $display("FAIL fill: got full=%b level=%0d, expected 1 16", full, level);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
    checks++;
    if (level !== 5'd16 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL wrap_level: got level=%0d ovr=%b, expected 16 0", level, overrun);
    end
    checks++;
    if (exp_q[0] !== 8'h04 || rd_data !== 8'h04) begin
      errors++;
      $display("FAIL wrap_head: got %h, expected 04", rd_data);
    end
    drain();
    checks++;
    if (last_pop !== 8'h13 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_tail: got last=%h valid=%b, expected 13 0", last_pop, rd_valid);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 16; i++) drive(1'b1, 8'($urandom_range(0, 200)), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    checks++;
    if (overrun !== 1'b1 || level !== 5'd16) begin
      errors++;
      $display("FAIL ovr_set: got ovr=%b level=%0d, expected 1 16", overrun, level);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clr: got %b, expected 0", overrun);
    end
    drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set_wins: got %b, expected 1", overrun);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    checks++;
    if (level !== 5'd16 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop: got level=%0d ovr=%b, expected 16 0", level, overrun);
    end
    drain();
    checks++;
    if (last_pop !== 8'h55) begin
      errors++;
      $display("FAIL full_push_pop_last: got %h, expected 55", last_pop);
    end
    drive(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    checks++;
    if (level !== 5'd1 || rd_data !== 8'h3C) begin
      errors++;
      $display("FAIL empty_push_ready: got level=%0d data=%h, expected 1 3c", level, rd_data);
    end
    drain();
  endtask

  task automatic test_thresh();
    thresh = 5'd4;
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    checks++;
    if (thresh_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_below: got %b, expected 0", thresh_irq);
    end
    drive(1'b1, 8'h23, 1'b0, 1'b0, 1'b0);
    checks++;
    if (thresh_irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_at: got %b, expected 1", thresh_irq);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (thresh_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_after_pop: got %b, expected 0", thresh_irq);
    end
    while (m_level < DEPTH) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    thresh = 5'd0;
    #1;
    checks++;
    if (thresh_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_disabled: got %b, expected 0", thresh_irq);
    end
    thresh = 5'd16;
    #1;
    checks++;
    if (thresh_irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_full: got %b, expected 1", thresh_irq);
    end
    thresh = 5'd0;
    drain();
  endtask

  task automatic test_flush();
    while (m_level < DEPTH) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (level !== 5'd5 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL pre_flush: got level=%0d ovr=%b, expected 5 1", level, overrun);
    end
    drive(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    checks++;
    if (level !== 5'd0 || rd_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL flush: got level=%0d valid=%b ovr=%b, expected 0 0 1",
               level, rd_valid, overrun);
    end
    drive(1'b1, 8'h81, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h82, 1'b0, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
    thresh = 5'd2;
    drive(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_level = 0;
    m_ovr   = 1'b0;
    checks++;
    if (level !== 5'd0 || rd_valid !== 1'b0 || full !== 1'b0 ||
        overrun !== 1'b0 || thresh_irq !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got level=%0d valid=%b full=%b ovr=%b irq=%b, expected all 0",
               level, rd_valid, full, overrun, thresh_irq);
    end
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    thresh = 5'd0;
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      thresh = 5'($urandom_range(0, 16));
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0),
            1'($urandom_range(0, 15) == 0));
      checks++;
      if (level !== 5'(m_level) || full !== (m_level == DEPTH) || overrun !== m_ovr ||
          thresh_irq !== ((thresh != 0) && (m_level >= int'(thresh)))) begin
        errors++;
        $display("FAIL b2b_status: got level=%0d full=%b ovr=%b irq=%b, expected level=%0d ovr=%b",
                 level, full, overrun, thresh_irq, m_level, m_ovr);
      end
    end
    thresh = 5'd0;
    drain();
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_data  = '0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    flush    = 1'b0;
    thresh   = '0;
    ovr_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_fill_wrap();
    test_overrun();
    test_thresh();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer that sits directly downstream of the UART receiver. It captures each received byte, announced by a one-cycle strobe, into a circular FIFO. Bytes leave through a show-ahead valid/ready port toward the AXI4-Lite register block. It also reports fill level, a programmable threshold interrupt, and a sticky overrun flag for the register map.

## Interface
- `DATA_W`, 8: byte width, matching the receiver's `data_out`.
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `LVL_W`, `$clog2(DEPTH)+1`: width of level and threshold values (localparam).

Ports:
- `clk`  in  1  single system clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `wr_data`  in  DATA_W  received byte from the UART receiver.
- `wr_valid`  in  1  push strobe; every high cycle is one byte.
- `rd_data`  out  DATA_W  head-of-FIFO byte; valid while `rd_valid`=1.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_ready`  in  1  consumer pop; a pop occurs when `rd_valid`&`rd_ready`.
- `flush`  in  1  synchronous empty request.
- `thresh`  in  LVL_W  interrupt threshold; 0 disables.
- `ovr_clr`  in  1  clears the sticky overrun flag.
- `level`  out  LVL_W  current entry count, 0..DEPTH.
- `full`  out  1  `level`==DEPTH.
- `overrun`  out  1  sticky: at least one byte was dropped on full.
- `thresh_irq`  out  1  (`thresh`≠0) & (`level` ≥ `thresh`).

## Operation
- Storage: DEPTH×DATA_W array; write pointer and read pointer are `$clog2(DEPTH)` bits and wrap naturally at DEPTH-1→0; separate `level` counter.
- Push accepted when `wr_valid` & (!`full` | pop this cycle) & !`flush`. It writes `mem[wptr]` and increments `wptr`.
- Pop when `rd_valid` & `rd_ready` & !`flush`: `rptr` increments.
- Level update: push-only +1; pop-only −1; push and pop together leaves it unchanged.
- Full and simultaneous push + pop: both are accepted, level stays DEPTH, no overrun.
- Empty and simultaneous push + `rd_ready`: no pop, because `rd_valid`=0; the push is accepted.
- Overrun: `wr_valid` while `full` with no pop: byte is dropped, memory and pointers are untouched, and `overrun` is set next cycle.
- `overrun` holds until `ovr_clr`. If a new overrun and `ovr_clr` occur in the same cycle, set wins.
- `flush`: next cycle `wptr`=`rptr`=0 and `level`=0. A same-cycle push is discarded without setting overrun. `overrun` is unaffected by flush.
- `rd_data` is driven combinationally from `mem[rptr]` (show-ahead). Contents are undefined when `rd_valid`=0.
- No state machine beyond the pointer/counter pair. Status outputs are derived from `level`.

## Timing
- Reset values: `level`=0, `rd_valid`=0, `full`=0, `overrun`=0, `thresh_irq`=0, pointers=0. `rd_data` is don't-care; the memory is not reset.
- Write latency: a byte pushed in cycle N is visible on `rd_data` with `rd_valid`=1 in cycle N+1.
- Pop: after a pop in cycle N, the next entry (or `rd_valid`=0) appears in cycle N+1.
- `level`, `full`, `thresh_irq` and `overrun` are registered, or derived only from registered state; they update the cycle after the causing event.
- Throughput: one push and one pop per cycle, sustained.
- Reset asserted mid-operation: all state returns to its reset values immediately and asynchronously; stored data is lost.
- `thresh` is sampled combinationally. If it changes, `thresh_irq` follows in the same cycle.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_W`=8
  - `UART_RX_FIFO_DEPTH`=16
  - typedef `uart_byte_t` (`logic [7:0]`)
  - The transmitter and register block also use this package.
- Sub-module `uart_fifo_mem`: simple dual-port array with synchronous write and asynchronous read, parameterised by DATA_W/DEPTH. It is reused later by the TX FIFO.
- Top-level `uart_rx_fifo` holds the pointers, level counter, flags and threshold compare.

## Test plan
- Single byte: after reset, push 0xA5 → next cycle `rd_valid`=1, `rd_data`=0xA5, `level`=1; pop → `level`=0, `rd_valid`=0.
- Fill and wrap:
  - Push 0x00..0x0F → `full`=1, `level`=16.
  - Pop 4 and push 0x10..0x13 → read order is 0x04..0x13, with no gaps.
- Overrun:
  - With the FIFO full, push 0xEE → `overrun`=1, 0xEE is never read, `level` stays 16.
  - `ovr_clr` → 0.
  - `ovr_clr` in the same cycle as a new drop → stays 1.
- Simultaneous push/pop:
  - When full: push 0x55 with pop → `level` stays 16, no overrun, 0x55 is read last.
  - When empty: push with `rd_ready`=1 → `level`=1.
- Threshold:
  - `thresh`=4: push 3 bytes → irq 0; push a 4th → irq 1; pop 1 → irq 0.
  - `thresh`=0 with FIFO full → irq 0.
- Flush and reset:
  - 5 entries plus `flush` with a concurrent push → `level`=0, `rd_valid`=0, `overrun` unchanged.
  - Assert `rst_n` low mid-stream → all outputs return to reset values asynchronously.
